mem_ctrl: RTL
=============

Name: mem_ctrl

Overview:
- Memory controller directly downstream of the MEM stage; also serves instruction fetch.
- Accepts word-level requests and serialises them onto a byte-wide synchronous RAM port. Loads are assembled little-endian; stores are split into bytes.
- Returns a one-cycle done pulse that releases the requester's stall.
- Arbitrates between the MEM-stage data port and the IF instruction port; data has priority.

Parameters:
- ADDR_WIDTH, 32, width of mem_a_o. Taken from the low bits of the 32-bit request address.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- ram_r_req_i  in  1  MEM-stage load request
- ram_w_req_i  in  1  MEM-stage store request
- ram_addr_i  in  32  MEM-stage byte address
- ram_w_data_i  in  32  store data; byte i = bits [8i+7:8i]
- ram_state_i  in  2  access size: 00 = 1 byte, 01 = 2, 11 = 4, 10 = 4 (reserved)
- ram_done_o  out  1  one-cycle completion pulse to MEM stage
- ram_r_data_o  out  32  load data, zero-filled above the access size
- if_req_i  in  1  instruction fetch request, always 4 bytes
- if_addr_i  in  32  fetch byte address
- if_done_o  out  1  one-cycle completion pulse to IF
- if_data_o  out  32  fetched instruction
- mem_a_o  out  ADDR_WIDTH  RAM byte address
- mem_wr_o  out  1  1 = write, 0 = read
- mem_dout_o  out  8  RAM write byte
- mem_din_i  in  8  RAM read byte, valid the cycle after its address is presented

Behaviour:
- Reset (rst low, asynchronous): state goes to IDLE. All outputs are 0: done pulses, data outputs, mem_a_o, mem_wr_o, mem_dout_o. Any in-flight transaction is dropped with no done pulse.
- Outputs are registered.
- States: IDLE, READ, WRITE, DONE.
- IDLE samples requests at each rising edge, in this priority order:
  - ram_w_req_i → WRITE
  - ram_r_req_i → READ
  - if_req_i → READ (IF owner)
  - ram_r_req_i and ram_w_req_i both high: the write wins.
- At acceptance, latch: base address, size N (1/2/4), write data, owner (MEM or IF).
- WRITE:
  - Write byte i during cycle i+1 after acceptance, for i = 0..N-1.
  - Drive mem_a_o = base+i, mem_wr_o = 1, mem_dout_o = byte i.
  - After the last byte, go to DONE.
- READ:
  - Present address base+i in cycle i+1, with mem_wr_o = 0.
  - Capture mem_din_i in cycle i+2 into byte lane i of an internal buffer.
  - Address issue and capture overlap, so the whole read takes N+1 cycles.
  - Unread lanes are 0.
- DONE:
  - Exactly one cycle.
  - Pulse the owner's done (ram_done_o or if_done_o).
  - Update the owner's data register in the same cycle; stores do not change ram_r_data_o.
  - Always return to IDLE. No request is sampled in DONE, so a held request is not re-issued.
  - Data registers hold their value until the next completion for the same owner.
- Latency, with the acceptance edge ending cycle 0: LW/fetch done in cycle 6, LH 4, LB 3; SW done in cycle 5, SH 3, SB 2.
- Address arithmetic: base+i wraps modulo 2^ADDR_WIDTH; no alignment check.
- While not in WRITE: mem_wr_o = 0, mem_dout_o = 0. While in IDLE/DONE: mem_a_o = 0.
- Requests deasserted mid-transaction do not abort it; done still pulses.
- Requests changed mid-transaction are ignored until the next IDLE.
- Never pulse both done outputs in the same cycle.

Test Plan:
- Reset/idle: rst low for 3 cycles, then high, no requests → all outputs 0; mem_wr_o stays 0.
- LW: RAM[0x100..0x103] = 78 56 34 12, ram_r_req_i, ram_state_i = 11, addr 0x100 → ram_done_o pulse in cycle 6, ram_r_data_o = 0x12345678; mem_a_o walks 0x100..0x103.
- SH then LB: store 0xBEEF to 0x202 with ram_state_i = 01 → writes EF@0x202, BE@0x203, done cycle 3. Then LB 0x203 → ram_r_data_o = 0x000000BE, done cycle 3.
- Arbitration: if_req_i (0x0) and ram_r_req_i (0x40) both high at the same edge → data served first with ram_done_o. Fetch is served in the following IDLE, with if_done_o 7 cycles after the data done; if_done_o never coincides with ram_done_o.
- Held request: ram_r_req_i held high through DONE and one extra cycle → exactly one ram_done_o per accepted transaction; the second transaction starts at the first IDLE edge after DONE.
- Reset mid-op: assert rst in cycle 3 of an SW to 0x10 → outputs 0 immediately; no done pulse; only bytes 0–1 were written.

Source files
------------

// File: rtl/mem_ctrl.sv
// Word-request to byte-wide RAM serialiser with MEM/IF arbitration.
// Loads are assembled little-endian, stores are split into bytes; completion is a one-cycle pulse.
module mem_ctrl #(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ram_r_req_i,
  input  logic                  ram_w_req_i,
  input  logic [31:0]           ram_addr_i,
  input  logic [31:0]           ram_w_data_i,
  input  logic [1:0]            ram_state_i,
  output logic                  ram_done_o,
  output logic [31:0]           ram_r_data_o,
  input  logic                  if_req_i,
  input  logic [31:0]           if_addr_i,
  output logic                  if_done_o,
  output logic [31:0]           if_data_o,
  output logic [ADDR_WIDTH-1:0] mem_a_o,
  output logic                  mem_wr_o,
  output logic [7:0]            mem_dout_o,
  input  logic [7:0]            mem_din_i
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

  state_e                r_state, w_state;
  logic [ADDR_WIDTH-1:0] r_base, w_base;
  logic [2:0]            r_size, w_size;
  logic [31:0]           r_wdata, w_wdata;
  logic                  r_owner_if, w_owner_if;
  logic [2:0]            r_cnt, w_cnt;
  logic [31:0]           r_buf, w_buf;

  logic                  r_ram_done, w_ram_done;
  logic [31:0]           r_ram_rdata, w_ram_rdata;
  logic                  r_if_done, w_if_done;
  logic [31:0]           r_if_data, w_if_data;
  logic [ADDR_WIDTH-1:0] r_mem_a, w_mem_a;
  logic                  r_mem_wr, w_mem_wr;
  logic [7:0]            r_mem_dout, w_mem_dout;

  logic [2:0]            w_cnt_inc;
  logic [2:0]            w_req_size;
  logic [1:0]            w_lane;
  logic [7:0]            w_next_byte;

  assign w_cnt_inc   = r_cnt + 3'd1;
  // The reserved encoding 10 is treated as a full word.
  assign w_req_size  = (ram_state_i == 2'b00) ? 3'd1 :
                       (ram_state_i == 2'b01) ? 3'd2 : 3'd4;
  // In READ, the byte arriving now belongs to the address issued one cycle earlier.
  assign w_lane      = 2'(r_cnt - 3'd1);
  assign w_next_byte = 8'(r_wdata >> {w_cnt_inc[1:0], 3'b000});

  always_comb begin
    w_state     = r_state;
    w_base      = r_base;
    w_size      = r_size;
    w_wdata     = r_wdata;
    w_owner_if  = r_owner_if;
    w_cnt       = r_cnt;
    w_buf       = r_buf;
    w_ram_done  = 1'b0;
    w_if_done   = 1'b0;
    w_ram_rdata = r_ram_rdata;
    w_if_data   = r_if_data;
    w_mem_a     = '0;
    w_mem_wr    = 1'b0;
    w_mem_dout  = 8'h00;

    case (r_state)
      StIdle: begin
        if (ram_w_req_i || ram_r_req_i || if_req_i) begin
          w_cnt = 3'd0;
          w_buf = 32'h0;
          if (ram_w_req_i || ram_r_req_i) begin
            w_base     = ram_addr_i[ADDR_WIDTH-1:0];
            w_size     = w_req_size;
            w_wdata    = ram_w_data_i;
            w_owner_if = 1'b0;
          end else begin
            w_base     = if_addr_i[ADDR_WIDTH-1:0];
            w_size     = 3'd4;
            w_wdata    = 32'h0;
            w_owner_if = 1'b1;
          end
          w_mem_a = w_base;
          if (ram_w_req_i) begin
            w_state    = StWrite;
            w_mem_wr   = 1'b1;
            w_mem_dout = ram_w_data_i[7:0];
          end else begin
            w_state = StRead;
          end
        end
      end

      StWrite: begin
        if (w_cnt_inc == r_size) begin
          w_state    = StDone;
          w_ram_done = 1'b1;
        end else begin
          w_cnt      = w_cnt_inc;
          w_mem_a    = r_base + ADDR_WIDTH'(w_cnt_inc);
          w_mem_wr   = 1'b1;
          w_mem_dout = w_next_byte;
        end
      end

      StRead: begin
        if (r_cnt != 3'd0) begin
          w_buf = r_buf | (32'(mem_din_i) << {w_lane, 3'b000});
        end
        if (r_cnt == r_size) begin
          w_state = StDone;
          if (r_owner_if) begin
            w_if_done = 1'b1;
            w_if_data = w_buf;
          end else begin
            w_ram_done  = 1'b1;
            w_ram_rdata = w_buf;
          end
        end else begin
          w_cnt = w_cnt_inc;
          // The final READ cycle only collects the last byte; no address is issued.
          if (w_cnt_inc != r_size) begin
            w_mem_a = r_base + ADDR_WIDTH'(w_cnt_inc);
          end
        end
      end

      StDone: begin
        w_state = StIdle;
      end

      default: begin
        w_state = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= StIdle;
      r_base      <= '0;
      r_size      <= 3'd0;
      r_wdata     <= 32'h0;
      r_owner_if  <= 1'b0;
      r_cnt       <= 3'd0;
      r_buf       <= 32'h0;
      r_ram_done  <= 1'b0;
      r_ram_rdata <= 32'h0;
      r_if_done   <= 1'b0;
      r_if_data   <= 32'h0;
      r_mem_a     <= '0;
      r_mem_wr    <= 1'b0;
      r_mem_dout  <= 8'h00;
    end else begin
      r_state     <= w_state;
      r_base      <= w_base;
      r_size      <= w_size;
      r_wdata     <= w_wdata;
      r_owner_if  <= w_owner_if;
      r_cnt       <= w_cnt;
      r_buf       <= w_buf;
      r_ram_done  <= w_ram_done;
      r_ram_rdata <= w_ram_rdata;
      r_if_done   <= w_if_done;
      r_if_data   <= w_if_data;
      r_mem_a     <= w_mem_a;
      r_mem_wr    <= w_mem_wr;
      r_mem_dout  <= w_mem_dout;
    end
  end

  assign ram_done_o   = r_ram_done;
  assign ram_r_data_o = r_ram_rdata;
  assign if_done_o    = r_if_done;
  assign if_data_o    = r_if_data;
  assign mem_a_o      = r_mem_a;
  assign mem_wr_o     = r_mem_wr;
  assign mem_dout_o   = r_mem_dout;

endmodule
